// File: rtl/sha_uart_ctrl.sv
// sha_uart_ctrl: frames a command byte plus a 64-byte block from the UART
// receiver, issues init/next to the SHA-256 core, then streams the 32-byte
// digest (or a single error byte) back out through the UART transmitter.
//
// Handshakes:
//   rx:  a byte is taken once per rising edge of rx_ready; rx_data is sampled
//        on that same cycle.
//   tx:  tx_start is a one-cycle request issued only while tx_busy is low;
//        tx_data stays put until the transmitter has gone busy and idle again.
//   sha: sha_init/sha_next pulse for one cycle only while sha_ready is high;
//        sha_block is frozen from the pulse until the digest is captured.
module sha_uart_ctrl #(
  parameter int          CLK_FREQ   = 200_000_000,
  parameter int          TIMEOUT_MS = 10,
  parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_ready,
  input  logic [7:0]   rx_data,
  input  logic         tx_busy,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic [511:0] sha_block,
  output logic         sha_init,
  output logic         sha_next,
  input  logic         sha_ready,
  input  logic [255:0] sha_digest,
  input  logic         sha_digest_valid,
  output logic         ctrl_busy,
  output logic         frame_err,
  output logic [2:0]   state_dbg
);

  localparam int TIMEOUT_CYC = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RX_BLOCK   = 3'd1,
    S_ISSUE      = 3'd2,
    S_WAIT_SHA   = 3'd3,
    S_TX_START   = 3'd4,
    S_TX_WAIT_HI = 3'd5,
    S_TX_WAIT_LO = 3'd6
  } state_t;

  state_t         state, state_nxt;
  logic           rx_q;
  logic           is_next;
  logic           err_mode;
  logic [6:0]     byte_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic [1:0]     guard_cnt;
  logic [255:0]   digest_sr;
  logic [5:0]     tx_cnt;

  logic rx_edge, cmd_ok, tmo_hit, last_byte;

  assign rx_edge   = rx_ready & ~rx_q;
  assign cmd_ok    = (rx_data == 8'h01) || (rx_data == 8'h02);
  assign tmo_hit   = (tmo_cnt == '0);
  assign last_byte = (byte_cnt == 7'd63);
  assign ctrl_busy = (state != S_IDLE);
  assign state_dbg = state;

  // Next-state decode; bytes arriving outside IDLE/RX_BLOCK are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (rx_edge) state_nxt = cmd_ok ? S_RX_BLOCK : S_TX_START;
      S_RX_BLOCK:   if (rx_edge) begin
                      if (last_byte) state_nxt = S_ISSUE;
                    end else if (tmo_hit) begin
                      state_nxt = S_TX_START;
                    end
      S_ISSUE:      if (sha_ready) state_nxt = S_WAIT_SHA;
      S_WAIT_SHA:   if (guard_cnt == 2'd0 && sha_digest_valid) state_nxt = S_TX_START;
      S_TX_START:   if (!tx_busy) state_nxt = S_TX_WAIT_HI;
      S_TX_WAIT_HI: if (tx_busy) state_nxt = S_TX_WAIT_LO;
      S_TX_WAIT_LO: if (!tx_busy) begin
                      if (err_mode || tx_cnt == 6'd1) state_nxt = S_IDLE;
                      else                            state_nxt = S_TX_START;
                    end
      default:      state_nxt = S_IDLE;
    endcase
  end

  // State register plus the datapath that each state drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rx_q      <= 1'b1;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      sha_block <= '0;
      sha_init  <= 1'b0;
      sha_next  <= 1'b0;
      frame_err <= 1'b0;
      is_next   <= 1'b0;
      err_mode  <= 1'b0;
      byte_cnt  <= 7'd0;
      tmo_cnt   <= TMO_LOAD;
      guard_cnt <= 2'd0;
      digest_sr <= '0;
      tx_cnt    <= 6'd0;
    end else begin
      state     <= state_nxt;
      rx_q      <= rx_ready;
      tx_start  <= 1'b0;
      sha_init  <= 1'b0;
      sha_next  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_edge) begin
            if (cmd_ok) begin
              is_next  <= (rx_data == 8'h02);
              err_mode <= 1'b0;
              byte_cnt <= 7'd0;
              tmo_cnt  <= TMO_LOAD;
            end else begin
              err_mode  <= 1'b1;
              frame_err <= 1'b1;
            end
          end
        end
        S_RX_BLOCK: begin
          if (rx_edge) begin
            sha_block <= {sha_block[503:0], rx_data};
            byte_cnt  <= byte_cnt + 7'd1;
            tmo_cnt   <= TMO_LOAD;
          end else if (tmo_hit) begin
            err_mode  <= 1'b1;
            frame_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
        end
        S_ISSUE: begin
          if (sha_ready) begin
            sha_init  <= ~is_next;
            sha_next  <= is_next;
            // Skip the pulse cycle and the one after: valid may still be
            // left over from the previous block.
            guard_cnt <= 2'd2;
          end
        end
        S_WAIT_SHA: begin
          if (guard_cnt != 2'd0) begin
            guard_cnt <= guard_cnt - 2'd1;
          end else if (sha_digest_valid) begin
            digest_sr <= sha_digest;
            tx_cnt    <= 6'd32;
          end
        end
        S_TX_START: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= err_mode ? ERR_BYTE : digest_sr[255:248];
          end
        end
        S_TX_WAIT_LO: begin
          if (!tx_busy) begin
            digest_sr <= {digest_sr[247:0], 8'h00};
            tx_cnt    <= tx_cnt - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_uart_ctrl.sv
// tb_sha_uart_ctrl: directed bench for sha_uart_ctrl with a behavioural
// SHA-256 core and a simple UART transmitter responder.
module tb_sha_uart_ctrl;

  localparam int          CLK_FREQ   = 20_000;  // 200-cycle timeout
  localparam int          TIMEOUT_MS = 10;
  localparam logic [7:0]  ERR_BYTE   = 8'hEE;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         rx_ready;
  logic [7:0]   rx_data;
  logic         tx_busy = 1'b0;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic [511:0] sha_block;
  logic         sha_init;
  logic         sha_next;
  logic         sha_ready = 1'b1;
  logic [255:0] sha_digest = '0;
  logic         sha_digest_valid = 1'b0;
  logic         ctrl_busy;
  logic         frame_err;
  logic [2:0]   state_dbg;

  always #5 clk = ~clk;

  sha_uart_ctrl #(
    .CLK_FREQ(CLK_FREQ), .TIMEOUT_MS(TIMEOUT_MS), .ERR_BYTE(ERR_BYTE)
  ) dut (
    .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .sha_block(sha_block), .sha_init(sha_init), .sha_next(sha_next),
    .sha_ready(sha_ready), .sha_digest(sha_digest),
    .sha_digest_valid(sha_digest_valid), .ctrl_busy(ctrl_busy),
    .frame_err(frame_err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_init = 0, n_next = 0, n_err = 0, n_tx = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- SHA-256 reference compression ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
           + w[i-7]  + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    for (int j = 0; j < 8; j++) v[j] = hin[255-32*j -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int j = 0; j < 8; j++) r[255-32*j -: 32] = hin[255-32*j -: 32] + v[j];
    return r;
  endfunction

  // ---------------- behavioural SHA core ----------------
  logic [255:0] h_state = '0;
  int           sha_lat = 0;

  always @(posedge clk) begin
    if (sha_lat != 0) begin
      sha_lat <= sha_lat - 1;
      if (sha_lat == 1) begin
        sha_digest       <= h_state;
        sha_digest_valid <= 1'b1;
        sha_ready        <= 1'b1;
      end
    end else if (sha_init || sha_next) begin
      h_state          <= sha_compress(sha_init ? IV : h_state, sha_block);
      sha_lat          <= 12;
      sha_ready        <= 1'b0;
      sha_digest_valid <= 1'b0;
    end
  end

  // ---------------- UART transmitter responder ----------------
  int busy_cnt = 0;

  always @(posedge clk) begin
    if (tx_start) begin
      tx_busy  <= 1'b1;
      busy_cnt <= 6;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) tx_busy <= 1'b0;
    end
  end

  // ---------------- monitor: pulse counts and tx byte scoreboard ----------------
  always @(negedge clk) begin
    if (sha_init === 1'b1)  n_init++;
    if (sha_next === 1'b1)  n_next++;
    if (frame_err === 1'b1) n_err++;
    if (tx_start === 1'b1) begin
      logic have;
      logic [7:0] e;
      n_tx++;
      have = (exp_q.size() != 0);
      e    = have ? exp_q.pop_front() : 8'h00;
      check("tx_byte", 512'({1'b1, tx_data}), have ? 512'({1'b1, e}) : 512'(0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    repeat (hold) @(negedge clk);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [511:0] blk, input int hold);
    send_byte(cmd, hold);
    for (int i = 0; i < 64; i++) send_byte(blk[511-8*i -: 8], hold);
  endtask

  task automatic push_digest(input logic [255:0] d);
    for (int i = 0; i < 32; i++) exp_q.push_back(d[255-8*i -: 8]);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ctrl_busy === 1'b0) break;
    end
    check(tag, 512'(ctrl_busy), 512'(0));
  endtask

  // ---------------- directed sequence ----------------
  logic [511:0] blk_abc, blk0, blk1;
  logic [447:0] msg56;
  int b_init, b_next, b_err, b_tx;

  task automatic snap();
    b_init = n_init; b_next = n_next; b_err = n_err; b_tx = n_tx;
  endtask

  initial begin
    msg56   = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    blk_abc = {32'h61626380, 416'h0, 64'h18};
    blk0    = {msg56, 8'h80, 56'h0};
    blk1    = {448'h0, 64'h1c0};

    rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx_start",  512'(tx_start),  512'(0));
    check("rst_tx_data",   512'(tx_data),   512'(0));
    check("rst_sha_block", sha_block,       512'(0));
    check("rst_sha_init",  512'(sha_init),  512'(0));
    check("rst_sha_next",  512'(sha_next),  512'(0));
    check("rst_ctrl_busy", 512'(ctrl_busy), 512'(0));
    check("rst_frame_err", 512'(frame_err), 512'(0));
    check("rst_state",     512'(state_dbg), 512'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // "abc" single block
    snap();
    push_digest(DIG_ABC);
    send_frame(8'h01, blk_abc, 2);
    check("abc_block", sha_block, blk_abc);
    wait_idle("abc_idle", 3000);
    check("abc_all_bytes", 512'(exp_q.size()), 512'(0));
    check("abc_tx_count",  512'(n_tx - b_tx),     512'(32));
    check("abc_init",      512'(n_init - b_init), 512'(1));
    check("abc_next",      512'(n_next - b_next), 512'(0));

    // two-block message: init then next; the intermediate digest comes
    // from the reference compression
    snap();
    push_digest(sha_compress(IV, blk0));
    send_frame(8'h01, blk0, 2);
    wait_idle("two_b0_idle", 3000);
    push_digest(DIG_TWO);
    send_frame(8'h02, blk1, 3);
    wait_idle("two_b1_idle", 3000);
    check("two_all_bytes", 512'(exp_q.size()), 512'(0));
    check("two_tx_count",  512'(n_tx - b_tx),     512'(64));
    check("two_init",      512'(n_init - b_init), 512'(1));
    check("two_next",      512'(n_next - b_next), 512'(1));

    // bad command
    snap();
    exp_q.push_back(ERR_BYTE);
    send_byte(8'h55, 2);
    wait_idle("bad_idle", 500);
    check("bad_all_bytes", 512'(exp_q.size()), 512'(0));
    check("bad_tx_count",  512'(n_tx - b_tx),     512'(1));
    check("bad_frame_err", 512'(n_err - b_err),   512'(1));
    check("bad_init",      512'(n_init - b_init), 512'(0));

    // timeout after 10 data bytes, then a good frame
    snap();
    exp_q.push_back(ERR_BYTE);
    send_byte(8'h01, 2);
    for (int i = 0; i < 10; i++) send_byte(8'(i + 8'h30), 2);
    check("tmo_still_rx", 512'(state_dbg), 512'(1));
    wait_idle("tmo_idle", 1000);
    check("tmo_all_bytes", 512'(exp_q.size()), 512'(0));
    check("tmo_tx_count",  512'(n_tx - b_tx),     512'(1));
    check("tmo_frame_err", 512'(n_err - b_err),   512'(1));
    check("tmo_state",     512'(state_dbg),       512'(0));
    check("tmo_init",      512'(n_init - b_init), 512'(0));
    snap();
    push_digest(DIG_ABC);
    send_frame(8'h01, blk_abc, 2);
    wait_idle("post_tmo_idle", 3000);
    check("post_tmo_bytes", 512'(exp_q.size()), 512'(0));
    check("post_tmo_tx",    512'(n_tx - b_tx),  512'(32));

    // rx_ready held high for 40 cycles per byte
    snap();
    push_digest(DIG_ABC);
    send_byte(8'h01, 40);
    for (int i = 0; i < 63; i++) send_byte(blk_abc[511-8*i -: 8], 40);
    check("held_pre64_state", 512'(state_dbg),       512'(1));
    check("held_pre64_init",  512'(n_init - b_init), 512'(0));
    check("held_pre64_tx",    512'(n_tx - b_tx),     512'(0));
    send_byte(blk_abc[7:0], 40);
    check("held_init", 512'(n_init - b_init), 512'(1));
    check("held_block", sha_block, blk_abc);
    wait_idle("held_idle", 3000);
    check("held_all_bytes", 512'(exp_q.size()), 512'(0));
    check("held_tx_count",  512'(n_tx - b_tx),  512'(32));

    // reset during the 5th digest byte
    snap();
    push_digest(DIG_ABC);
    send_frame(8'h01, blk_abc, 2);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (n_tx - b_tx >= 5) break;
    end
    check("rst5_reached", 512'(n_tx - b_tx), 512'(5));
    rst = 1'b1;
    @(negedge clk);
    check("rst5_tx_start",  512'(tx_start),  512'(0));
    check("rst5_ctrl_busy", 512'(ctrl_busy), 512'(0));
    check("rst5_state",     512'(state_dbg), 512'(0));
    rst = 1'b0;
    exp_q.delete();
    repeat (30) @(negedge clk);
    check("rst5_no_more_tx", 512'(n_tx - b_tx), 512'(5));
    snap();
    push_digest(DIG_ABC);
    send_frame(8'h01, blk_abc, 2);
    wait_idle("rst5_new_idle", 3000);
    check("rst5_new_bytes", 512'(exp_q.size()), 512'(0));
    check("rst5_new_tx",    512'(n_tx - b_tx),  512'(32));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
